// File: rtl/ex_operand_stage.sv
// ex_operand_stage
// ID/EX pipeline register feeding the execute-stage ALU. Latches one decoded
// instruction per cycle, resolves its source operands through EX/MEM and
// MEM/WB forwarding, detects load-use hazards (stalling ID and inserting a
// bubble) and squashes its contents on a flush.
//
// Build option: macro EX_FORWARDING_EN
//   defined   - EX/MEM and MEM/WB forwarding; only load-use hazards stall.
//   undefined - no forwarding; ID stalls while any in-flight writer
//               (EX, EX/MEM, MEM/WB) targets one of its nonzero sources.
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   id_*                       decoded instruction from ID
//   flush                      redirect; squash EX contents, no stall
//   exm_rd/regwrite/result     EX/MEM destination and ALU result
//   wb_rd/regwrite/result      MEM/WB destination and writeback data
//   SrcA, SrcB, Operation      ALU inputs
//   ex_valid/regwrite/memread  EX-stage control
//   ex_rd                      EX-stage destination
//   ex_store_data              forwarded rs2 value for stores
//   stall_id                   hold PC and IF/ID this cycle
module ex_operand_stage #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4,
   parameter int REG_ADDR      = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     id_valid,
   input  logic [REG_ADDR-1:0]      id_rs1,
   input  logic [REG_ADDR-1:0]      id_rs2,
   input  logic [REG_ADDR-1:0]      id_rd,
   input  logic [DATA_WIDTH-1:0]    id_rd1,
   input  logic [DATA_WIDTH-1:0]    id_rd2,
   input  logic [DATA_WIDTH-1:0]    id_imm,
   input  logic [DATA_WIDTH-1:0]    id_pc,
   input  logic                     id_alusrc,
   input  logic                     id_asel_pc,
   input  logic [OPCODE_LENGTH-1:0] id_operation,
   input  logic                     id_regwrite,
   input  logic                     id_memread,
   input  logic                     flush,
   input  logic [REG_ADDR-1:0]      exm_rd,
   input  logic                     exm_regwrite,
   input  logic [DATA_WIDTH-1:0]    exm_result,
   input  logic [REG_ADDR-1:0]      wb_rd,
   input  logic                     wb_regwrite,
   input  logic [DATA_WIDTH-1:0]    wb_result,
   output logic [DATA_WIDTH-1:0]    SrcA,
   output logic [DATA_WIDTH-1:0]    SrcB,
   output logic [OPCODE_LENGTH-1:0] Operation,
   output logic                     ex_valid,
   output logic                     ex_regwrite,
   output logic                     ex_memread,
   output logic [REG_ADDR-1:0]      ex_rd,
   output logic [DATA_WIDTH-1:0]    ex_store_data,
   output logic                     stall_id
);

   logic                     r_valid;
   logic                     r_alusrc;
   logic                     r_asel_pc;
   logic                     r_regwrite;
   logic                     r_memread;
   logic [REG_ADDR-1:0]      r_rs1;
   logic [REG_ADDR-1:0]      r_rs2;
   logic [REG_ADDR-1:0]      r_rd;
   logic [DATA_WIDTH-1:0]    r_rd1;
   logic [DATA_WIDTH-1:0]    r_rd2;
   logic [DATA_WIDTH-1:0]    r_imm;
   logic [DATA_WIDTH-1:0]    r_pc;
   logic [OPCODE_LENGTH-1:0] r_op;

   logic                     w_hazard;
   logic                     w_bubble;
   logic [DATA_WIDTH-1:0]    w_fwd_rs1;
   logic [DATA_WIDTH-1:0]    w_fwd_rs2;

`ifdef EX_FORWARDING_EN
   // EX/MEM is checked first so the youngest producer wins; x0 never matches.
   always_comb begin
      w_fwd_rs1 = r_rd1;
      if (exm_regwrite && (exm_rd != '0) && (exm_rd == r_rs1))
         w_fwd_rs1 = exm_result;
      else if (wb_regwrite && (wb_rd != '0) && (wb_rd == r_rs1))
         w_fwd_rs1 = wb_result;
   end

   always_comb begin
      w_fwd_rs2 = r_rd2;
      if (exm_regwrite && (exm_rd != '0) && (exm_rd == r_rs2))
         w_fwd_rs2 = exm_result;
      else if (wb_regwrite && (wb_rd != '0) && (wb_rd == r_rs2))
         w_fwd_rs2 = wb_result;
   end

   // Only a load in EX cannot be forwarded in time for the next instruction.
   assign w_hazard = r_valid & r_memread & (r_rd != '0) & id_valid &
                     ((r_rd == id_rs1) | (r_rd == id_rs2));
`else
   function automatic logic f_busy(input logic [REG_ADDR-1:0] rs);
      return (rs != '0) &&
             ((r_valid && r_regwrite && (r_rd == rs)) ||
              (exm_regwrite && (exm_rd == rs)) ||
              (wb_regwrite && (wb_rd == rs)));
   endfunction

   assign w_fwd_rs1 = r_rd1;
   assign w_fwd_rs2 = r_rd2;

   // Without forwarding or write-through, any pending writer of a source
   // register blocks ID until it has retired.
   assign w_hazard = id_valid & (f_busy(id_rs1) | f_busy(id_rs2));

   logic w_unused_fwd;
   assign w_unused_fwd = ^{exm_result, wb_result, r_rs1, r_rs2};
`endif

   // Flush overrides the hazard: the dependent instruction is being squashed.
   assign stall_id = w_hazard & ~flush;
   assign w_bubble = flush | w_hazard;

   always_ff @(posedge clk or posedge reset) begin
      if (reset || w_bubble) begin
         r_valid    <= 1'b0;
         r_alusrc   <= 1'b0;
         r_asel_pc  <= 1'b0;
         r_regwrite <= 1'b0;
         r_memread  <= 1'b0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_rd       <= '0;
         r_rd1      <= '0;
         r_rd2      <= '0;
         r_imm      <= '0;
         r_pc       <= '0;
         r_op       <= '0;
      end else begin
         r_valid    <= id_valid;
         r_alusrc   <= id_alusrc;
         r_asel_pc  <= id_asel_pc;
         r_regwrite <= id_regwrite;
         r_memread  <= id_memread;
         r_rs1      <= id_rs1;
         r_rs2      <= id_rs2;
         r_rd       <= id_rd;
         r_rd1      <= id_rd1;
         r_rd2      <= id_rd2;
         r_imm      <= id_imm;
         r_pc       <= id_pc;
         r_op       <= id_operation;
      end
   end

   assign SrcA          = r_asel_pc ? r_pc  : w_fwd_rs1;
   assign SrcB          = r_alusrc  ? r_imm : w_fwd_rs2;
   assign ex_store_data = w_fwd_rs2;
   assign Operation     = r_op;
   assign ex_valid      = r_valid;
   assign ex_regwrite   = r_regwrite;
   assign ex_memread    = r_memread;
   assign ex_rd         = r_rd;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

`ifdef EX_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid, id_alusrc, id_asel_pc, id_regwrite, id_memread, flush;
   logic [4:0]  id_rs1, id_rs2, id_rd, exm_rd, wb_rd;
   logic [31:0] id_rd1, id_rd2, id_imm, id_pc, exm_result, wb_result;
   logic [3:0]  id_operation;
   logic        exm_regwrite, wb_regwrite;
   logic [31:0] SrcA, SrcB, ex_store_data;
   logic [3:0]  Operation;
   logic        ex_valid, ex_regwrite, ex_memread, stall_id;
   logic [4:0]  ex_rd;

   int tests = 0;
   int fails = 0;

   ex_operand_stage dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc(id_pc),
      .id_alusrc(id_alusrc), .id_asel_pc(id_asel_pc), .id_operation(id_operation),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
      .exm_rd(exm_rd), .exm_regwrite(exm_regwrite), .exm_result(exm_result),
      .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_result(wb_result),
      .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
      .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .ex_rd(ex_rd), .ex_store_data(ex_store_data), .stall_id(stall_id)
   );

   always #5 clk = ~clk;

   // Reference: the instruction currently sitting in EX, as a record.
   typedef struct packed {
      logic        valid;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] rd1, rd2, imm, pc;
      logic        alusrc, asel_pc;
      logic [3:0]  op;
      logic        regwrite, memread;
   } instr_t;

   instr_t m = '0;
   logic   last_stall = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Value an ALU source register should have right now.
   function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] file_val);
      if (FWD && rs != 0 && exm_regwrite && exm_rd == rs) return exm_result;
      if (FWD && rs != 0 && wb_regwrite && wb_rd == rs) return wb_result;
      return file_val;
   endfunction

   function automatic bit pending_writer(input logic [4:0] rs);
      if (rs == 0) return 0;
      return (m.valid && m.regwrite && m.rd == rs) ||
             (exm_regwrite && exm_rd == rs) || (wb_regwrite && wb_rd == rs);
   endfunction

   function automatic bit exp_stall();
      if (flush || !id_valid) return 0;
      if (FWD)
         return m.valid && m.memread && m.rd != 0 && (m.rd == id_rs1 || m.rd == id_rs2);
      return pending_writer(id_rs1) || pending_writer(id_rs2);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m = '0;
         last_stall = 0;
      end else begin
         last_stall = exp_stall();
         if (flush || last_stall) m = '0;
         else m = '{id_valid, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm, id_pc,
                    id_alusrc, id_asel_pc, id_operation, id_regwrite, id_memread};
      end
   end

   // Compare process: every cycle, mid low phase.
   always @(negedge clk) begin
      chk("srca",      SrcA,          m.asel_pc ? m.pc  : operand(m.rs1, m.rd1));
      chk("srcb",      SrcB,          m.alusrc  ? m.imm : operand(m.rs2, m.rd2));
      chk("store",     ex_store_data, operand(m.rs2, m.rd2));
      chk("operation", 32'(Operation),   32'(m.op));
      chk("ex_valid",  32'(ex_valid),    32'(m.valid));
      chk("ex_regwr",  32'(ex_regwrite), 32'(m.regwrite));
      chk("ex_memrd",  32'(ex_memread),  32'(m.memread));
      chk("ex_rd",     32'(ex_rd),       32'(m.rd));
      chk("stall_id",  32'(stall_id),    32'(exp_stall()));
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rd1 = 0; id_rd2 = 0;
      id_imm = 0; id_pc = 0; id_alusrc = 0; id_asel_pc = 0; id_operation = 0;
      id_regwrite = 0; id_memread = 0; flush = 0;
      exm_rd = 0; exm_regwrite = 0; exm_result = 0;
      wb_rd = 0; wb_regwrite = 0; wb_result = 0;
   endtask

   task automatic drive_add_x8_x7_x7();
      id_valid = 1; id_rs1 = 7; id_rs2 = 7; id_rd = 8;
      id_rd1 = 32'h1234; id_rd2 = 32'h1234; id_regwrite = 1; id_operation = 0;
   endtask

   task automatic drive_lw_x7();
      id_valid = 1; id_rs1 = 2; id_rd = 7; id_memread = 1; id_regwrite = 1;
   endtask

   initial begin
      idle();
      reset = 1;
      repeat (2) @(posedge clk);
      #2 reset = 0;
      settle();
      chk("rst_srca",  SrcA, 0);
      chk("rst_op",    32'(Operation), 0);
      chk("rst_valid", 32'(ex_valid), 0);
      chk("rst_stall", 32'(stall_id), 0);

      // EX/MEM beats MEM/WB on the same register
      tick(); idle();
      id_valid = 1; id_rs1 = 5; id_rs2 = 1; id_rd = 6;
      id_rd1 = 32'hAAAA; id_rd2 = 32'h1; id_operation = 4'd1; id_regwrite = 1;
      tick(); idle();
      exm_rd = 5; exm_regwrite = 1; exm_result = 32'h10;
      wb_rd = 5; wb_regwrite = 1; wb_result = 32'h99;
      settle();
      chk("fwd_srca", SrcA, FWD ? 32'h10 : 32'hAAAA);
      chk("fwd_srcb", SrcB, 32'h1);
      chk("fwd_op",   32'(Operation), 1);

      // x0 never forwards
      tick(); idle();
      id_valid = 1;
      tick(); idle();
      exm_rd = 0; exm_regwrite = 1; exm_result = 32'hFFFF;
      settle();
      chk("x0_srca", SrcA, 0);

      // load-use: one stall, one bubble, then operands from MEM/WB
      tick(); idle(); drive_lw_x7();
      tick(); idle(); drive_add_x8_x7_x7();
      settle();
      chk("lu_stall1", 32'(stall_id), 1);
      tick();
      exm_rd = 7; exm_regwrite = 1; exm_result = 32'h4444;
      settle();
      chk("lu_bubble", 32'(ex_valid), 0);
      chk("lu_stall2", 32'(stall_id), FWD ? 0 : 1);
      tick();
      exm_regwrite = 0; wb_rd = 7; wb_regwrite = 1; wb_result = 32'h5555;
      settle();
      chk("lu_srca",   SrcA, FWD ? 32'h5555 : 32'h0);
      chk("lu_srcb",   SrcB, FWD ? 32'h5555 : 32'h0);
      chk("lu_valid",  32'(ex_valid), FWD ? 1 : 0);
      chk("lu_stall3", 32'(stall_id), FWD ? 0 : 1);

      // flush in the same cycle as a load-use hazard
      tick(); idle(); drive_lw_x7();
      tick(); idle(); drive_add_x8_x7_x7(); flush = 1;
      settle();
      chk("fl_stall", 32'(stall_id), 0);
      tick(); idle();
      settle();
      chk("fl_valid", 32'(ex_valid), 0);

      // immediate and PC select
      tick(); idle();
      id_valid = 1; id_alusrc = 1; id_imm = 32'h800; id_asel_pc = 1; id_pc = 32'h100;
      id_rs1 = 4; id_rd1 = 32'h4444; id_rs2 = 3; id_rd2 = 32'h3333;
      tick(); idle();
      settle();
      chk("sel_srca",  SrcA, 32'h100);
      chk("sel_srcb",  SrcB, 32'h800);
      chk("sel_store", ex_store_data, 32'h3333);

      // asynchronous reset while an instruction is in EX
      tick(); idle();
      id_valid = 1; id_operation = 4'b0010; id_rd = 9; id_regwrite = 1; id_pc = 32'h40;
      id_asel_pc = 1;
      tick(); idle();
      settle();
      chk("pre_valid", 32'(ex_valid), 1);
      chk("pre_op",    32'(Operation), 2);
      #2 reset = 1;
      #1;
      chk("ar_valid", 32'(ex_valid), 0);
      chk("ar_op",    32'(Operation), 0);
      chk("ar_srca",  SrcA, 0);
      chk("ar_srcb",  SrcB, 0);
      chk("ar_rd",    32'(ex_rd), 0);
      chk("ar_stall", 32'(stall_id), 0);
      tick(); reset = 0;

      // randomized traffic; ID holds its instruction while stalled
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (!last_stall) begin
            id_valid     = 1'($urandom_range(0, 3) != 0);
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_rd        = 5'($urandom_range(0, 3));
            id_rd1       = $urandom;
            id_rd2       = $urandom;
            id_imm       = $urandom;
            id_pc        = $urandom;
            id_alusrc    = 1'($urandom_range(0, 1));
            id_asel_pc   = 1'($urandom_range(0, 1));
            id_operation = 4'($urandom_range(0, 15));
            id_regwrite  = 1'($urandom_range(0, 1));
            id_memread   = 1'($urandom_range(0, 1));
         end
         exm_rd       = 5'($urandom_range(0, 3));
         exm_regwrite = 1'($urandom_range(0, 1));
         exm_result   = $urandom;
         wb_rd        = 5'($urandom_range(0, 3));
         wb_regwrite  = 1'($urandom_range(0, 1));
         wb_result    = $urandom;
         flush        = 1'($urandom_range(0, 9) == 0);
         reset        = 1'($urandom_range(0, 199) == 0);
      end
      tick(); reset = 0; idle();
      settle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX boundary stage of the pipeline, sitting directly upstream of the execute-stage ALU. Each cycle it registers one decoded instruction and drives the ALU's `SrcA`, `SrcB` and `Operation` inputs. Operands are resolved through EX/MEM and MEM/WB forwarding. The stage detects load-use hazards, stalls the ID stage and inserts bubbles, and squashes its contents on a pipeline flush.

## Interface

- `DATA_WIDTH`, 32, operand/result width
- `OPCODE_LENGTH`, 4, ALU operation code width
- `REG_ADDR`, 5, register index width

Ports:

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `id_valid`  in  1  ID holds a real instruction
- `id_rs1`, `id_rs2`, `id_rd`  in  REG_ADDR  source and destination indices
- `id_rd1`, `id_rd2`  in  DATA_WIDTH  register-file read data
- `id_imm`, `id_pc`  in  DATA_WIDTH  immediate, instruction PC
- `id_alusrc`  in  1  SrcB = immediate
- `id_asel_pc`  in  1  SrcA = PC
- `id_operation`  in  OPCODE_LENGTH  ALU code
- `id_regwrite`, `id_memread`  in  1  writes rd / is a load
- `flush`  in  1  branch/jump redirect; squash ID and EX
- `exm_rd`  in  REG_ADDR  EX/MEM destination
- `exm_regwrite`  in  1  EX/MEM destination valid
- `exm_result`  in  DATA_WIDTH  EX/MEM ALU result
- `wb_rd`  in  REG_ADDR  MEM/WB destination
- `wb_regwrite`  in  1  MEM/WB destination valid
- `wb_result`  in  DATA_WIDTH  writeback data
- `SrcA`, `SrcB`  out  DATA_WIDTH  ALU operands
- `Operation`  out  OPCODE_LENGTH  ALU code
- `ex_valid`, `ex_regwrite`, `ex_memread`  out  1  EX-stage control
- `ex_rd`  out  REG_ADDR  EX-stage destination
- `ex_store_data`  out  DATA_WIDTH  forwarded rs2 value, for stores
- `stall_id`  out  1  hold PC and IF/ID this cycle

## Operation

**Stage register**
- The stage register holds all `id_*` fields.
- It loads every cycle unless a bubble or flush applies.

**Forwarding (combinational, from registered rs1/rs2)**
- EX/MEM is selected if `exm_regwrite`, `exm_rd != 0` and `exm_rd == rs`.
- Otherwise MEM/WB is selected if `wb_regwrite`, `wb_rd != 0` and `wb_rd == rs`.
- Otherwise the registered read data is used.
- EX/MEM has priority over MEM/WB.
- Register x0 never forwards.

**Operand selection**
- `SrcA` = `asel_pc ? pc : fwd_rs1`.
- `SrcB` = `alusrc ? imm : fwd_rs2`.
- `ex_store_data` = `fwd_rs2` always.

**Load-use hazard**
- `stall_id` = `ex_valid & ex_memread & ex_rd != 0 & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2)`.
- On a stall, the next state is a bubble: `ex_valid`, `ex_regwrite`, `ex_memread` and `Operation` load 0, and all data fields load 0.
- On a stall, ID holds its instruction.

**Flush**
- `flush` loads a bubble and forces `stall_id = 0`.
- Flush has priority over stall.

**Reset**
- All registered fields are 0.
- Therefore `SrcA = SrcB = 0`, `Operation = 4'b0000`, `ex_valid = 0` and `stall_id = 0`, unless forwarding inputs match rd 0, which they never do.
- A reset mid-stall drops the held hazard state.

## Timing

- An `id_*` value sampled at edge N appears on `SrcA`/`SrcB`/`Operation` after edge N, within the same cycle.
- Latency is 1 cycle.
- Forwarding and `stall_id` are purely combinational from the current-cycle inputs and registered state.
- A load followed immediately by a dependent instruction costs exactly 1 bubble; the dependent instruction then takes its operand from MEM/WB.
- Back-to-back ALU dependencies cost 0 bubbles via EX/MEM.

## Configuration

- Macro: `EX_FORWARDING_EN`.

**Defined**
- Behaviour is as above.

**Undefined**
- No forwarding; operands always come from registered read data.
- `stall_id` asserts whenever `id_valid` and a nonzero `id_rs1`/`id_rs2` matches any of:
  - `ex_rd` with `ex_regwrite & ex_valid`;
  - `exm_rd` with `exm_regwrite`;
  - `wb_rd` with `wb_regwrite`.
- The register file is not write-through.
- Each stall cycle loads a bubble.
- Flush priority is unchanged.

## Test plan

- **Reset mid-operation:** assert `reset` with `ex_valid = 1`, `Operation = 0010` → all outputs are 0 immediately, without waiting for a clock edge.
- **EX/MEM forwarding:** `add x5`, then `sub x6, x5, x1` with `exm_rd = 5`, `exm_result = 0x10`, `wb_rd = 5`, `wb_result = 0x99` → `SrcA = 0x10` (EX/MEM wins).
- **Load-use stall:** `lw x7`, then `add x8, x7, x7` → `stall_id = 1` for one cycle, one bubble (`ex_valid = 0`), then `SrcA = SrcB = wb_result`.
- **x0 never forwards:** `exm_rd = 0` with `exm_regwrite = 1`, `exm_result = 0xFFFF` and `rs1 = 0` → `SrcA = id_rd1 = 0`.
- **Flush over stall:** flush in the same cycle as a load-use hazard → `stall_id = 0` and `ex_valid = 0` next cycle.
- **Immediate and PC select:** `id_alusrc = 1`, `id_imm = 0x800`, `id_asel_pc = 1`, `id_pc = 0x100` → `SrcA = 0x100`, `SrcB = 0x800`, and `ex_store_data` equals the forwarded rs2.
